// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared constants for the memory arbiter, its counters, the memory model
// and both caches: line geometry, memory latency, FSM state encoding and
// small address helpers.
package memory_arbiter_pkg;

    localparam int WORDS_PER_LINE   = 8;
    localparam int MEM_LATENCY      = 4;
    localparam int ADDR_W           = 16;
    localparam int DATA_W           = 16;
    localparam int LINE_OFFSET_BITS = 4;
    localparam int WORD_BYTES       = 2;
    localparam int CNT_W            = $clog2(WORDS_PER_LINE);

    // Arbiter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Line base of any byte address: low offset bits forced to zero.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

    // Byte address of word idx within the line starting at base.
    // Wraps modulo 2^ADDR_W; a line never crosses because base is aligned.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/memory_arbiter_line_word_counter.sv
// line_word_counter
// Word index within a cache line. Counts 0..WORDS_PER_LINE-1 and saturates:
// the enable that arrives while at the last index sets 'full' instead of
// wrapping, so the owner can tell "on last word" from "all words done".
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         synchronous clear of count and full
//   enable        advance by one (ignored once full)
//   count         current word index
//   at_last       count is the final index of the line
//   full          every index has been consumed
module line_word_counter
    import memory_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             at_last,
    output logic             full
);

    assign at_last = (count == CNT_W'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            full  <= 1'b0;
        end else if (enable && !full) begin
            if (at_last) begin
                full <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one main-memory port between the I-cache (line fills) and the
// D-cache (line fills and write-through single-word stores).
//
// Handshake: a cache raises req (with addr, and for D also wr/wdata) and
// holds it until its done pulse. grant is high from the first FILL/WRITE
// cycle through the done cycle. A line fill returns WORDS_PER_LINE words
// with fill_valid, each tagged with its byte address; done pulses together
// with the last word. A write completes in one cycle with done. Dropping
// req mid-transaction does not abort it.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   i_req, i_addr                  I-cache miss request / address
//   i_grant, i_fill_*, i_done      I-cache ownership, returned words, done
//   d_req, d_wr, d_addr, d_wdata   D-cache request (write or line fill)
//   d_grant, d_fill_*, d_done      D-cache ownership, returned words, done
//   mem_enable, mem_wr, mem_addr,
//   mem_wdata                      memory command port
//   mem_rdata, mem_rvalid          memory read return (fixed latency)
//   dbg_state                      current FSM state
module memory_arbiter
    import memory_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_fill_valid,
    output logic [DATA_W-1:0] i_fill_data,
    output logic [ADDR_W-1:0] i_fill_addr,
    output logic              i_done,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_grant,
    output logic              d_fill_valid,
    output logic [DATA_W-1:0] d_fill_data,
    output logic [ADDR_W-1:0] d_fill_addr,
    output logic              d_done,

    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,

    output logic [1:0]        dbg_state
);

    logic [1:0]        state;
    logic              last_was_d;
    logic              owner_d;     // 1: current transaction belongs to D
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [CNT_W-1:0]  issue_cnt;
    logic              issue_last;
    logic              issue_full;
    logic [CNT_W-1:0]  recv_cnt;
    logic              recv_last;
    logic              recv_full;

    logic              any_req;
    logic              pick_d;
    logic              in_fill;
    logic              issue_en;
    logic              fill_fire;
    logic              line_done;
    logic [ADDR_W-1:0] fill_addr;

    // The in-line offset of an I-cache miss address is irrelevant.
    logic              unused_i_offset;
    assign unused_i_offset = ^{i_addr[LINE_OFFSET_BITS-1:0], issue_last};

    // D wins a tie unless it won the previous grant.
    assign any_req   = i_req || d_req;
    assign pick_d    = d_req && (!i_req || !last_was_d);

    assign in_fill   = (state == ST_FILL);
    assign issue_en  = in_fill && !issue_full;
    // Returns after the whole line has arrived are dropped.
    assign fill_fire = in_fill && mem_rvalid && !recv_full;
    assign line_done = fill_fire && recv_last;
    assign fill_addr = word_addr(base, recv_cnt);

    line_word_counter u_issue_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .enable  (issue_en),
        .count   (issue_cnt),
        .at_last (issue_last),
        .full    (issue_full)
    );

    line_word_counter u_recv_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .enable  (fill_fire),
        .count   (recv_cnt),
        .at_last (recv_last),
        .full    (recv_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_was_d <= 1'b0;
            owner_d    <= 1'b0;
            base       <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state      <= (pick_d && d_wr) ? ST_WRITE : ST_FILL;
                        owner_d    <= pick_d;
                        last_was_d <= pick_d;
                        base       <= line_base(pick_d ? d_addr : i_addr);
                        wr_addr    <= d_addr;
                        wr_data    <= d_wdata;
                    end
                end
                ST_FILL: begin
                    if (line_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registered state, so grant never glitches
    // and everything is zero as soon as reset asserts.
    always_comb begin
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_fill_data  = '0;
        d_fill_data  = '0;
        i_fill_addr  = '0;
        d_fill_addr  = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (state != ST_IDLE) begin
            i_grant = !owner_d;
            d_grant = owner_d;
        end

        if (issue_en) begin
            mem_enable = 1'b1;
            mem_addr   = word_addr(base, issue_cnt);
        end

        if (fill_fire) begin
            if (owner_d) begin
                d_fill_valid = 1'b1;
                d_fill_data  = mem_rdata;
                d_fill_addr  = fill_addr;
                d_done       = line_done;
            end else begin
                i_fill_valid = 1'b1;
                i_fill_data  = mem_rdata;
                i_fill_addr  = fill_addr;
                i_done       = line_done;
            end
        end

        if (state == ST_WRITE) begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = wr_addr;
            mem_wdata  = wr_data;
            d_done     = 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed bench for memory_arbiter with a fixed-latency memory model whose
// read data is (address ^ 16'h5A5A).
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_grant, i_fill_valid, i_done;
    logic [15:0] i_fill_data, i_fill_addr;

    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_grant, d_fill_valid, d_done;
    logic [15:0] d_fill_data, d_fill_addr;

    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rvalid;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic        pv [MEM_LATENCY-1];
    logic [15:0] pa [MEM_LATENCY-1];
    logic        m_rvalid;
    logic [15:0] m_rdata;
    logic        stray_v = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MEM_LATENCY-1; k++) pv[k] <= 1'b0;
            m_rvalid <= 1'b0;
            m_rdata  <= '0;
        end else begin
            pv[0] <= mem_enable && !mem_wr;
            pa[0] <= mem_addr;
            for (int k = 1; k < MEM_LATENCY-1; k++) begin
                pv[k] <= pv[k-1];
                pa[k] <= pa[k-1];
            end
            m_rvalid <= pv[MEM_LATENCY-2];
            m_rdata  <= pv[MEM_LATENCY-2] ? (pa[MEM_LATENCY-2] ^ 16'h5A5A) : 16'h0000;
        end
    end

    assign mem_rvalid = m_rvalid | stray_v;
    assign mem_rdata  = stray_v ? 16'hDEAD : m_rdata;

    memory_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_grant      (i_grant),
        .i_fill_valid (i_fill_valid),
        .i_fill_data  (i_fill_data),
        .i_fill_addr  (i_fill_addr),
        .i_done       (i_done),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_grant      (d_grant),
        .d_fill_valid (d_fill_valid),
        .d_fill_data  (d_fill_data),
        .d_fill_addr  (d_fill_addr),
        .d_done       (d_done),
        .mem_enable   (mem_enable),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .dbg_state    (dbg_state)
    );

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " i_grant"},      32'(i_grant),      0);
        check({tag, " i_fill_valid"}, 32'(i_fill_valid), 0);
        check({tag, " i_fill_data"},  32'(i_fill_data),  0);
        check({tag, " i_fill_addr"},  32'(i_fill_addr),  0);
        check({tag, " i_done"},       32'(i_done),       0);
        check({tag, " d_grant"},      32'(d_grant),      0);
        check({tag, " d_fill_valid"}, 32'(d_fill_valid), 0);
        check({tag, " d_fill_data"},  32'(d_fill_data),  0);
        check({tag, " d_fill_addr"},  32'(d_fill_addr),  0);
        check({tag, " d_done"},       32'(d_done),       0);
        check({tag, " mem_enable"},   32'(mem_enable),   0);
        check({tag, " mem_wr"},       32'(mem_wr),       0);
        check({tag, " mem_addr"},     32'(mem_addr),     0);
        check({tag, " mem_wdata"},    32'(mem_wdata),    0);
        check({tag, " dbg_state"},    32'(dbg_state),    0);
    endtask

    // Called in the IDLE cycle in which the winning request is visible.
    // Walks cycles 1..12 of the fill, then the IDLE cycle after done.
    // drop[0]/drop[1] release i_req/d_req with the done cycle; queue_i
    // raises an I request during the first fill cycle.
    task automatic run_fill(input bit is_d, input logic [15:0] base, input bit [1:0] drop,
                            input bit queue_i, input logic [15:0] q_addr);
        logic        own_grant, oth_grant, own_fv, oth_fv, own_done, oth_done;
        logic [15:0] own_fa, own_fd;
        logic [15:0] exp_ma, exp_fa;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (queue_i && c == 1) begin
                i_req  = 1'b1;
                i_addr = q_addr;
            end
            own_grant = is_d ? d_grant : i_grant;
            oth_grant = is_d ? i_grant : d_grant;
            own_fv    = is_d ? d_fill_valid : i_fill_valid;
            oth_fv    = is_d ? i_fill_valid : d_fill_valid;
            own_done  = is_d ? d_done : i_done;
            oth_done  = is_d ? i_done : d_done;
            own_fa    = is_d ? d_fill_addr : i_fill_addr;
            own_fd    = is_d ? d_fill_data : i_fill_data;
            exp_ma    = base + 16'(2 * (c - 1));
            exp_fa    = base + 16'(2 * (c - 5));

            check("fill own_grant", 32'(own_grant), 1);
            check("fill other_grant", 32'(oth_grant), 0);
            check("fill mem_wr", 32'(mem_wr), 0);
            check("fill mem_enable", 32'(mem_enable), (c <= 8) ? 1 : 0);
            if (c <= 8) check("fill mem_addr", 32'(mem_addr), 32'(exp_ma));
            check("fill own_valid", 32'(own_fv), (c >= 5) ? 1 : 0);
            check("fill other_valid", 32'(oth_fv), 0);
            if (c >= 5) begin
                check("fill own_addr", 32'(own_fa), 32'(exp_fa));
                check("fill own_data", 32'(own_fd), 32'(exp_fa ^ 16'h5A5A));
            end
            check("fill own_done", 32'(own_done), (c == 12) ? 1 : 0);
            check("fill other_done", 32'(oth_done), 0);
        end
        if (drop[0]) i_req = 1'b0;
        if (drop[1]) d_req = 1'b0;
        tick;
        check("post i_grant", 32'(i_grant), 0);
        check("post d_grant", 32'(d_grant), 0);
        check("post mem_enable", 32'(mem_enable), 0);
        check("post dbg_state", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;
        tick;
        check_idle("after_reset");

        // I fill alone: line 0x1230..0x123E
        i_req  = 1'b1;
        i_addr = 16'h1236;
        run_fill(1'b0, 16'h1230, 2'b01, 1'b0, 16'h0000);

        // Both fill requests held: D, I, D, I
        i_req  = 1'b1;
        i_addr = 16'h400F;
        d_req  = 1'b1;
        d_wr   = 1'b0;
        d_addr = 16'h3008;
        run_fill(1'b1, 16'h3000, 2'b00, 1'b0, 16'h0000);
        run_fill(1'b0, 16'h4000, 2'b00, 1'b0, 16'h0000);
        run_fill(1'b1, 16'h3000, 2'b00, 1'b0, 16'h0000);
        run_fill(1'b0, 16'h4000, 2'b11, 1'b0, 16'h0000);

        // D write-through store
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h2004;
        d_wdata = 16'hBEEF;
        tick;
        check("wr mem_enable", 32'(mem_enable), 1);
        check("wr mem_wr",     32'(mem_wr),     1);
        check("wr mem_addr",   32'(mem_addr),   32'h2004);
        check("wr mem_wdata",  32'(mem_wdata),  32'hBEEF);
        check("wr d_done",     32'(d_done),     1);
        check("wr d_grant",    32'(d_grant),    1);
        check("wr i_grant",    32'(i_grant),    0);
        check("wr d_fill_valid", 32'(d_fill_valid), 0);
        d_req = 1'b0;
        d_wr  = 1'b0;
        tick;
        check("wr_after mem_enable", 32'(mem_enable), 0);
        check("wr_after d_grant",    32'(d_grant),    0);
        check("wr_after d_done",     32'(d_done),     0);

        // D fill, then I fill queued during it; I first issue at done+2
        d_req  = 1'b1;
        d_addr = 16'h5013;
        run_fill(1'b1, 16'h5010, 2'b10, 1'b1, 16'h602A);
        run_fill(1'b0, 16'h6020, 2'b01, 1'b0, 16'h0000);

        // Stray mem_rvalid while IDLE
        stray_v = 1'b1;
        #1;
        check("stray i_fill_valid", 32'(i_fill_valid), 0);
        check("stray d_fill_valid", 32'(d_fill_valid), 0);
        check("stray i_fill_data",  32'(i_fill_data),  0);
        tick;
        stray_v = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h7008;
        run_fill(1'b0, 16'h7000, 2'b01, 1'b0, 16'h0000);

        // Reset in the middle of a fill, after the 3rd returned word
        i_req  = 1'b1;
        i_addr = 16'h0100;
        repeat (7) tick;
        check("midrst i_fill_valid", 32'(i_fill_valid), 1);
        check("midrst i_fill_addr",  32'(i_fill_addr),  32'h0104);
        rst = 1'b0;
        #1;
        check_idle("midrst");
        i_req = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check_idle("midrst_release");
        i_req  = 1'b1;
        i_addr = 16'h0040;
        run_fill(1'b0, 16'h0040, 2'b01, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
